// File: rtl/maxnet_host.sv
// Initiator for the Maxnet start/done job interface: packs four operand words,
// launches the core, waits for done (with timeout) and returns the result.
module maxnet_host #(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_W          = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    input  logic [31:0]      epsilon_cfg,
    output logic             mx_start,
    output logic [31:0]      mx_epsilon,
    output logic [31:0]      mx_num1,
    output logic [31:0]      mx_num2,
    output logic [31:0]      mx_num3,
    output logic [31:0]      mx_num4,
    input  logic             mx_done,
    input  logic [31:0]      mx_max,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic             out_err,
    output logic             busy,
    output logic [CNT_W-1:0] job_count
);

    localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        COLLECT,
        START,
        WAIT,
        RESP
    } state_t;

    state_t        state;
    state_t        next_state;
    logic [1:0]    idx;
    logic [TW-1:0] tmo_cnt;
    logic [31:0]   num [4];
    logic          accept;
    logic          timeout;

    assign accept   = in_valid && (state == COLLECT);
    assign timeout  = (tmo_cnt == TMO_LAST);

    assign in_ready  = (state == COLLECT);
    assign mx_start  = (state == START);
    assign out_valid = (state == RESP);
    assign busy      = (state != COLLECT);

    assign mx_num1 = num[0];
    assign mx_num2 = num[1];
    assign mx_num3 = num[2];
    assign mx_num4 = num[3];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= COLLECT;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            COLLECT: if (accept && (idx == 2'd3)) next_state = START;
            START:   next_state = WAIT;
            WAIT:    if (mx_done || timeout) next_state = RESP;
            RESP:    if (out_ready) next_state = COLLECT;
            default: next_state = COLLECT;
        endcase
    end

    // Operand packing; the registers stay frozen from START until the next job writes them.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx        <= 2'd0;
            mx_epsilon <= 32'd0;
            for (int i = 0; i < 4; i++) begin
                num[i] <= 32'd0;
            end
        end else if (accept) begin
            num[idx] <= in_data;
            idx      <= idx + 2'd1;
            if (idx == 2'd3) begin
                mx_epsilon <= epsilon_cfg;
            end
        end
    end

    // Done is only honoured in WAIT and takes priority over the timeout.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tmo_cnt   <= '0;
            out_data  <= 32'd0;
            out_err   <= 1'b0;
            job_count <= '0;
        end else begin
            case (state)
                START: tmo_cnt <= '0;
                WAIT: begin
                    if (mx_done) begin
                        out_data <= mx_max;
                        out_err  <= 1'b0;
                    end else if (timeout) begin
                        out_data <= 32'd0;
                        out_err  <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + TW'(1);
                    end
                end
                RESP: if (out_ready) job_count <= job_count + CNT_W'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_maxnet_host.sv
// Directed bench for maxnet_host: one instance with the default timeout for
// the data-path scenarios and a second with an 8-cycle timeout.
module tb_maxnet_host;

    logic        clk = 1'b0;
    logic        rst;
    logic        sel;
    logic        in_valid;
    logic [31:0] in_data;
    logic [31:0] epsilon_cfg;
    logic        mx_done;
    logic [31:0] mx_max;
    logic        out_ready;

    logic        in_valid_a, mx_done_a, out_ready_a;
    logic        in_valid_b, mx_done_b, out_ready_b;
    logic        in_ready_a, mx_start_a, out_valid_a, out_err_a, busy_a;
    logic        in_ready_b, mx_start_b, out_valid_b, out_err_b, busy_b;
    logic [31:0] mx_eps_a, n1_a, n2_a, n3_a, n4_a, out_data_a;
    logic [31:0] mx_eps_b, n1_b, n2_b, n3_b, n4_b, out_data_b;
    logic [15:0] job_count_a, job_count_b;

    logic        in_ready, mx_start, out_valid, out_err, busy;
    logic [31:0] out_data;
    logic [15:0] job_count;

    int checks = 0;
    int fails  = 0;

    logic [31:0] words [8] = '{32'd1, 32'd8, 32'd3, 32'd2, 32'd10, 32'd4, 32'd30, 32'd7};
    logic [31:0] maxes [2] = '{32'd8, 32'd30};
    logic [31:0] results [2];

    always #5 clk = ~clk;

    // sel routes the shared stimulus to instance A (0) or B (1); the idle one sees zeros.
    assign in_valid_a  = in_valid & ~sel;
    assign mx_done_a   = mx_done & ~sel;
    assign out_ready_a = out_ready & ~sel;
    assign in_valid_b  = in_valid & sel;
    assign mx_done_b   = mx_done & sel;
    assign out_ready_b = out_ready & sel;

    assign in_ready  = sel ? in_ready_b  : in_ready_a;
    assign mx_start  = sel ? mx_start_b  : mx_start_a;
    assign out_valid = sel ? out_valid_b : out_valid_a;
    assign out_err   = sel ? out_err_b   : out_err_a;
    assign busy      = sel ? busy_b      : busy_a;
    assign out_data  = sel ? out_data_b  : out_data_a;
    assign job_count = sel ? job_count_b : job_count_a;

    maxnet_host dut_a (
        .clk(clk), .rst(rst),
        .in_valid(in_valid_a), .in_ready(in_ready_a), .in_data(in_data),
        .epsilon_cfg(epsilon_cfg),
        .mx_start(mx_start_a), .mx_epsilon(mx_eps_a),
        .mx_num1(n1_a), .mx_num2(n2_a), .mx_num3(n3_a), .mx_num4(n4_a),
        .mx_done(mx_done_a), .mx_max(mx_max),
        .out_valid(out_valid_a), .out_ready(out_ready_a),
        .out_data(out_data_a), .out_err(out_err_a),
        .busy(busy_a), .job_count(job_count_a)
    );

    maxnet_host #(.TIMEOUT_CYCLES(8), .CNT_W(16)) dut_b (
        .clk(clk), .rst(rst),
        .in_valid(in_valid_b), .in_ready(in_ready_b), .in_data(in_data),
        .epsilon_cfg(epsilon_cfg),
        .mx_start(mx_start_b), .mx_epsilon(mx_eps_b),
        .mx_num1(n1_b), .mx_num2(n2_b), .mx_num3(n3_b), .mx_num4(n4_b),
        .mx_done(mx_done_b), .mx_max(mx_max),
        .out_valid(out_valid_b), .out_ready(out_ready_b),
        .out_data(out_data_b), .out_err(out_err_b),
        .busy(busy_b), .job_count(job_count_b)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offers one word and waits (bounded) for the handshake edge.
    task automatic applyStimulus(input logic [31:0] d);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = d;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) checkOutput("push_timeout", 32'(n), 32'd0);
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        int k, nres, starts, delay, early, cyc;
        logic acc, hs;

        rst = 1'b0; sel = 1'b0; in_valid = 1'b0; in_data = '0;
        epsilon_cfg = '0; mx_done = 1'b0; mx_max = '0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
        checkOutput("rst_mx_start", 32'(mx_start), 32'd0);
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_out_data", out_data, 32'd0);
        checkOutput("rst_out_err", 32'(out_err), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_job_count", 32'(job_count), 32'd0);
        checkOutput("rst_num1", n1_a, 32'd0);
        checkOutput("rst_eps", mx_eps_a, 32'd0);
        rst = 1'b1;
        tick();
        checkOutput("post_rst_start", 32'(mx_start), 32'd0);

        $display("[TB] normal job");
        epsilon_cfg = 32'h0000_0100;
        applyStimulus(32'd5); applyStimulus(32'd17); applyStimulus(32'd9); applyStimulus(32'd3);
        epsilon_cfg = 32'h0000_FFFF;
        checkOutput("start_pulse", 32'(mx_start), 32'd1);
        checkOutput("start_busy", 32'(busy), 32'd1);
        checkOutput("start_in_ready", 32'(in_ready), 32'd0);
        checkOutput("num1", n1_a, 32'd5);
        checkOutput("num2", n2_a, 32'd17);
        checkOutput("num3", n3_a, 32'd9);
        checkOutput("num4", n4_a, 32'd3);
        checkOutput("epsilon", mx_eps_a, 32'h100);
        tick();
        checkOutput("start_one_cycle", 32'(mx_start), 32'd0);
        repeat (20) tick();
        checkOutput("wait_no_valid", 32'(out_valid), 32'd0);
        mx_done = 1'b1; mx_max = 32'd17;
        tick();
        mx_done = 1'b0; mx_max = 32'd0;
        checkOutput("res_valid", 32'(out_valid), 32'd1);
        checkOutput("res_data", out_data, 32'd17);
        checkOutput("res_err", 32'(out_err), 32'd0);

        $display("[TB] backpressure");
        in_valid = 1'b1; in_data = 32'hDEAD;
        for (int i = 0; i < 10; i++) begin
            tick();
            checkOutput("bp_valid", 32'(out_valid), 32'd1);
            checkOutput("bp_data", out_data, 32'd17);
            checkOutput("bp_in_ready", 32'(in_ready), 32'd0);
        end
        checkOutput("bp_not_consumed", n1_a, 32'd5);
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0; out_ready = 1'b0;
        checkOutput("bp_release_in_ready", 32'(in_ready), 32'd1);
        checkOutput("bp_release_valid", 32'(out_valid), 32'd0);
        checkOutput("job_count_1", 32'(job_count), 32'd1);
        checkOutput("bp_num1_kept", n1_a, 32'd5);

        $display("[TB] reset mid-job");
        applyStimulus(32'd1); applyStimulus(32'd2); applyStimulus(32'd3); applyStimulus(32'd4);
        tick(); tick();
        rst = 1'b0;
        #1;
        checkOutput("mid_rst_in_ready", 32'(in_ready), 32'd1);
        checkOutput("mid_rst_start", 32'(mx_start), 32'd0);
        checkOutput("mid_rst_valid", 32'(out_valid), 32'd0);
        checkOutput("mid_rst_count", 32'(job_count), 32'd0);
        checkOutput("mid_rst_busy", 32'(busy), 32'd0);
        checkOutput("mid_rst_num1", n1_a, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checkOutput("post_rst_no_start", 32'(mx_start), 32'd0);
            checkOutput("post_rst_no_valid", 32'(out_valid), 32'd0);
        end

        $display("[TB] stray done");
        mx_done = 1'b1; mx_max = 32'd99;
        tick();
        mx_done = 1'b0;
        checkOutput("stray_collect_in_ready", 32'(in_ready), 32'd1);
        checkOutput("stray_collect_valid", 32'(out_valid), 32'd0);
        epsilon_cfg = 32'h20;
        applyStimulus(32'd6); applyStimulus(32'd2); applyStimulus(32'd8); applyStimulus(32'd4);
        checkOutput("stray_start", 32'(mx_start), 32'd1);
        mx_done = 1'b1; mx_max = 32'd99;
        tick();
        mx_done = 1'b0;
        checkOutput("stray_start_valid", 32'(out_valid), 32'd0);
        checkOutput("stray_wait_busy", 32'(busy), 32'd1);
        repeat (5) tick();
        checkOutput("stray_still_waiting", 32'(out_valid), 32'd0);
        mx_done = 1'b1; mx_max = 32'd8;
        tick();
        mx_done = 1'b0;
        checkOutput("stray_res_valid", 32'(out_valid), 32'd1);
        checkOutput("stray_res_data", out_data, 32'd8);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checkOutput("stray_job_count", 32'(job_count), 32'd1);

        $display("[TB] timeout");
        sel = 1'b1;
        applyStimulus(32'd1); applyStimulus(32'd2); applyStimulus(32'd3); applyStimulus(32'd4);
        checkOutput("tmo_start", 32'(mx_start), 32'd1);
        repeat (8) tick();
        checkOutput("tmo_8th_wait_valid", 32'(out_valid), 32'd0);
        checkOutput("tmo_8th_wait_busy", 32'(busy), 32'd1);
        tick();
        checkOutput("tmo_valid", 32'(out_valid), 32'd1);
        checkOutput("tmo_data", out_data, 32'd0);
        checkOutput("tmo_err", 32'(out_err), 32'd1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checkOutput("tmo_job_count", 32'(job_count), 32'd1);
        applyStimulus(32'd5); applyStimulus(32'd6); applyStimulus(32'd7); applyStimulus(32'd8);
        repeat (8) tick();
        checkOutput("race_not_yet", 32'(out_valid), 32'd0);
        mx_done = 1'b1; mx_max = 32'd77;
        tick();
        mx_done = 1'b0;
        checkOutput("race_valid", 32'(out_valid), 32'd1);
        checkOutput("race_err", 32'(out_err), 32'd0);
        checkOutput("race_data", out_data, 32'd77);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checkOutput("race_job_count", 32'(job_count), 32'd2);

        $display("[TB] back-to-back");
        sel = 1'b0;
        rst = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        checkOutput("b2b_count_clear", 32'(job_count), 32'd0);
        k = 0; nres = 0; starts = 0; delay = 0; early = 0; cyc = 0;
        in_valid = 1'b1; in_data = words[0]; out_ready = 1'b1;
        while (nres < 2 && cyc < 200) begin
            acc = in_valid && in_ready;
            hs  = out_valid && out_ready;
            mx_done = 1'b0;
            if (mx_start) begin
                starts++;
                delay = 3;
            end else if (delay > 0) begin
                delay--;
                if (delay == 0) begin
                    mx_done = 1'b1;
                    mx_max  = maxes[(starts - 1) & 1];
                end
            end
            if (hs) begin
                results[nres & 1] = out_data;
                nres++;
            end
            if (acc && k >= 4 && nres == 0) early++;
            tick();
            if (acc) begin
                k++;
                if (k >= 8) in_valid = 1'b0;
                else in_data = words[k];
            end
            cyc++;
        end
        in_valid = 1'b0; out_ready = 1'b0; mx_done = 1'b0;
        checkOutput("b2b_no_timeout", 32'(cyc >= 200), 32'd0);
        checkOutput("b2b_starts", 32'(starts), 32'd2);
        checkOutput("b2b_words", 32'(k), 32'd8);
        checkOutput("b2b_result0", results[0], 32'd8);
        checkOutput("b2b_result1", results[1], 32'd30);
        checkOutput("b2b_early_accept", 32'(early), 32'd0);
        tick();
        checkOutput("b2b_job_count", 32'(job_count), 32'd2);
        checkOutput("b2b_idle", 32'(busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/maxnet_host.md
Name: maxnet_host

Overview:
- Initiator side of the Maxnet start/done job interface.
- Accepts a valid/ready stream of 32-bit words and packs each group of four into num1..num4.
- Issues a one-cycle start to the Maxnet core, waits for done, then captures max and returns it on an output valid/ready stream.
- A timeout guards against a core that never asserts done.

Parameters:
- TIMEOUT_CYCLES, 1024: max cycles spent in WAIT before the job is aborted (≥2).
- CNT_W, 16: width of the completed-job counter.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- in_valid  in  1  operand word valid
- in_ready  out  1  operand word accepted when in_valid&in_ready
- in_data  in  32  operand word; 1st→num1 … 4th→num4
- epsilon_cfg  in  32  inhibition constant for the next job
- mx_start  out  1  one-cycle job start to Maxnet core
- mx_epsilon  out  32  registered epsilon for current job
- mx_num1..mx_num4  out  32 each  registered operands
- mx_done  in  1  job complete from core
- mx_max  in  32  result from core, valid while mx_done=1
- out_valid  out  1  result available
- out_ready  in  1  downstream accepts result
- out_data  out  32  captured max (0 on timeout)
- out_err  out  1  1 = job timed out
- busy  out  1  high in START/WAIT/RESP
- job_count  out  CNT_W  number of results delivered (ok or err)

Behaviour:
- Reset (rst=0, async):
  - state=COLLECT, word index=0, timeout counter=0.
  - All outputs 0 except in_ready=1 (COLLECT).
  - mx_num*, mx_epsilon, out_data and job_count clear to 0.
- Reset mid-job aborts immediately: no further mx_start, and no result is produced.
- COLLECT:
  - in_ready=1.
  - Each handshake writes in_data to mx_num[idx] and increments idx (2-bit).
  - On the 4th handshake: idx wraps to 0, mx_epsilon←epsilon_cfg (sampled that cycle), state→START.
  - in_valid with in_ready=0 (any other state) is ignored and not consumed.
- START:
  - mx_start=1 for exactly this one cycle; in_ready=0.
  - Next state is WAIT; the timeout counter is cleared.
- WAIT:
  - mx_done is sampled only in this state. mx_done during START or COLLECT is ignored.
  - On mx_done=1: out_data←mx_max, out_err←0, state→RESP.
  - Otherwise the counter increments. If the counter reaches TIMEOUT_CYCLES-1 with no done: out_data←0, out_err←1, state→RESP.
  - If done and timeout occur in the same cycle, done wins.
- RESP:
  - out_valid=1; out_data and out_err are held stable until out_ready.
  - On out_valid&out_ready: job_count increments (wraps at 2^CNT_W), out_valid→0 next cycle, state→COLLECT.
  - out_ready high on the first RESP cycle gives a one-cycle result.
- Latency:
  - 4th word accepted at cycle N → mx_start high at N+1 → WAIT from N+2.
  - mx_done at cycle M → out_valid at M+1.
  - Result accepted at cycle K → in_ready=1 at K+1.
- mx_num*/mx_epsilon are held constant from START until the next job's first write. The core may read them throughout WAIT.
- busy = (state != COLLECT).

Test Plan:
- Reset values: assert rst=0 mid-WAIT → immediately in_ready=1, mx_start=0, out_valid=0, job_count=0. Releasing rst yields no spurious mx_start.
- Normal job: stream 5,17,9,3 with epsilon_cfg=0x00000100 → mx_num1..4=5,17,9,3 and mx_epsilon=0x100. mx_start high exactly 1 cycle at N+1. Core model returns done with max=17 after 20 cycles → out_data=17, out_err=0, job_count=1.
- Backpressure:
  - Hold out_ready=0 for 10 cycles in RESP → out_valid and out_data=17 remain stable, in_ready=0 throughout, and offered in_data words are not consumed.
  - Then out_ready=1 → in_ready=1 the next cycle.
- Timeout: TIMEOUT_CYCLES=8 with a core that never asserts done → out_valid with out_data=0, out_err=1 after 8 WAIT cycles. job_count increments. A done=1 in the same cycle as the last timeout count gives out_err=0 instead.
- Stray done: pulse mx_done during COLLECT and during START → ignored. The job still waits for a done in WAIT.
- Back-to-back: two jobs, in_valid held high with 8 words and out_ready=1 → two mx_start pulses, results delivered in order, job_count=2. Words 5–8 are accepted only after the first result handshake.
